// File: rtl/cgp_fitness_eval_if.sv
// Handshake and result bundle between the evolution controller and the CGP fitness evaluator.
// The evaluator takes the slave modport and the controller takes the master modport.
interface cgp_fitness_eval_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int DW    = $clog2((2**N_IN)*N_OUT+1)
);
  logic             start_i;
  logic             abort_i;
  logic [1:0]       mode_i;
  logic [N_OUT-1:0] exp_i;
  logic             clear_best_i;
  logic [N_IN-1:0]  pat_o;
  logic [N_OUT-1:0] dut_i;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [DW-1:0]    dist_o;
  logic [DW-1:0]    matches_o;
  logic [DW-1:0]    total_o;
  logic [DW-1:0]    best_dist_o;
  logic             improved_o;

  modport master (
    output start_i, abort_i, mode_i, exp_i, clear_best_i, dut_i,
    input  pat_o, busy_o, done_o, aborted_o, dist_o, matches_o, total_o,
           best_dist_o, improved_o
  );

  modport slave (
    input  start_i, abort_i, mode_i, exp_i, clear_best_i, dut_i,
    output pat_o, busy_o, done_o, aborted_o, dist_o, matches_o, total_o,
           best_dist_o, improved_o
  );
endinterface

// File: rtl/cgp_fitness_eval.sv
// Sweeps every input pattern into a combinational CGP candidate, scores its outputs
// against a selectable target function, and keeps the best Hamming distance seen.
module cgp_fitness_eval #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1,
  parameter int DW     = $clog2((2**N_IN)*N_OUT+1)
) (
  input logic               clk,
  input logic               rst,
  cgp_fitness_eval_if.slave bus
);

  localparam int            CW    = $clog2(SETTLE+1);
  localparam logic [DW-1:0] TOTAL = DW'((2**N_IN)*N_OUT);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  pat_q, pat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [1:0]       mode_q, mode_d;
  logic [DW-1:0]    dist_q, dist_d;
  logic [DW-1:0]    matches_q, matches_d;
  logic [DW-1:0]    best_q, best_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             improved_q, improved_d;

  logic             sample;
  logic             last_pat;
  logic             reduced;
  logic [N_OUT-1:0] expected;
  logic [N_OUT-1:0] diff;
  logic [DW-1:0]    mism;

  // "Would reach 0" on this edge means the counter currently reads 1.
  assign sample   = (state_q == S_DRIVE) && (cnt_q == CW'(1));
  assign last_pat = &pat_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    reduced = 1'b0;
    case (mode_q)
      2'd0:    reduced = ^pat_q;
      2'd1:    reduced = &pat_q;
      2'd2:    reduced = |pat_q;
      default: reduced = 1'b0;
    endcase
    expected = (mode_q == 2'd3) ? bus.exp_i : {N_OUT{reduced}};
    diff     = bus.dut_i ^ expected;
    mism     = '0;
    for (int i = 0; i < N_OUT; i++) mism = mism + DW'(diff[i]);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort takes priority over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start_i) state_d = S_DRIVE;
      S_DRIVE:  if (bus.abort_i) state_d = S_IDLE;
                else if (sample && last_pat) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    dist_d     = dist_q;
    matches_d  = matches_q;
    best_d     = best_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    improved_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start_i) begin
        mode_d = bus.mode_i;
        pat_d  = '0;
        acc_d  = '0;
        cnt_d  = CW'(SETTLE);
      end
      S_DRIVE: begin
        if (bus.abort_i) begin
          aborted_d = 1'b1;
        end else if (sample) begin
          acc_d = acc_q + mism;
          if (!last_pat) begin
            pat_d = pat_q + 1'b1;
            cnt_d = CW'(SETTLE);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: begin
        if (bus.abort_i) begin
          aborted_d = 1'b1;
        end else begin
          dist_d    = acc_q;
          // Exactly half wrong is no better than a random guess, so it scores zero.
          matches_d = ({acc_q, 1'b0} == {1'b0, TOTAL}) ? '0 : TOTAL - acc_q;
          done_d    = 1'b1;
          if (acc_q < best_q) begin
            best_d     = acc_q;
            improved_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (bus.clear_best_i) begin
      best_d     = '1;
      improved_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mode_q     <= '0;
      dist_q     <= '0;
      matches_q  <= '0;
      best_q     <= '1;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      improved_q <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      dist_q     <= dist_d;
      matches_q  <= matches_d;
      best_q     <= best_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      improved_q <= improved_d;
    end
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.pat_o       = pat_q;
  assign bus.done_o      = done_q;
  assign bus.aborted_o   = aborted_q;
  assign bus.dist_o      = dist_q;
  assign bus.matches_o   = matches_q;
  assign bus.total_o     = TOTAL;
  assign bus.best_dist_o = best_q;
  assign bus.improved_o  = improved_q;

endmodule

// File: doc/cgp_fitness_eval.md
# cgp_fitness_eval

Synthesizable fitness evaluator for evolved CGP candidate circuits. It sweeps all 2^N_IN input patterns into a combinational candidate, waits a programmable settle time, and compares every candidate output bit against a selectable target function. It accumulates the Hamming distance and reports a match count, with an exact-half result scored as zero. It also tracks the best distance across runs, so the evolution controller can score candidates in hardware instead of in simulation.

## Interface
- N_IN, 4: candidate input count; the sweep covers 2^N_IN patterns.
- N_OUT, 1: candidate output count; every bit is compared.
- SETTLE, 1: cycles each pattern is held before sampling; must be ≥1.
- DW, $clog2((2**N_IN)*N_OUT+1): width of the count outputs, derived.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begins a run when sampled in IDLE.
- abort_i  in  1  cancels a run in progress.
- mode_i  in  2  target function: 0 parity, 1 AND-reduce, 2 OR-reduce, 3 external.
- exp_i  in  N_OUT  expected outputs, used in mode 3 only.
- clear_best_i  in  1  resets best_dist_o to all-ones.
- pat_o  out  N_IN  pattern driven into the candidate inputs (registered).
- dut_i  in  N_OUT  candidate outputs.
- busy_o  out  1  high while a run is active.
- done_o  out  1  one-cycle pulse when a run completes.
- aborted_o  out  1  one-cycle pulse when a run is cancelled.
- dist_o  out  DW  Hamming distance of the last completed run.
- matches_o  out  DW  match count of the last completed run, after the half rule.
- total_o  out  DW  constant, equal to 2^N_IN·N_OUT.
- best_dist_o  out  DW  minimum dist_o since reset or clear.
- improved_o  out  1  one-cycle pulse, coincident with done_o, when best_dist_o decreased.

## Operation
- States:
  - IDLE: no run active.
  - DRIVE: hold the current pattern for SETTLE cycles, then sample.
  - FINISH: publish results.
- Reset values:
  - pat_o=0, busy_o=0, done_o=0, aborted_o=0, improved_o=0.
  - dist_o=0, matches_o=0, best_dist_o=all-ones.
  - Internal accumulator=0, state=IDLE.
  - Reset mid-run abandons the run immediately. No done or aborted pulse is produced.
- IDLE + start_i:
  - Latch mode_i.
  - Set pat_o=0 and the accumulator to 0.
  - Load the settle counter with SETTLE.
  - Go to DRIVE with busy_o=1.
  - start_i is ignored when not in IDLE. abort_i is ignored in IDLE.
- DRIVE:
  - The counter decrements each cycle.
  - On the edge where it would reach 0:
    - Compute expected bits: modes 0–2 replicate reduce(pat_o) to all N_OUT bits; mode 3 uses exp_i sampled on this edge.
    - Add popcount(dut_i ^ expected) to the accumulator.
  - Then either:
    - If pat_o is all-ones (last pattern), go to FINISH.
    - Otherwise increment pat_o and reload the counter with SETTLE.
- FINISH (one cycle):
  - dist_o ← accumulator.
  - matches_o ← 0 if 2·acc == total, else total − acc.
  - done_o=1.
  - If acc < best_dist_o: best_dist_o ← acc and improved_o=1.
  - busy_o drops and the state returns to IDLE.
  - pat_o holds its last value until the next start.
- abort_i in DRIVE or FINISH:
  - Return to IDLE and pulse aborted_o.
  - dist_o, matches_o and best_dist_o are not updated. done_o is not pulsed.
  - Abort wins over completion on the same edge.
- clear_best_i:
  - Sets best_dist_o to all-ones on any edge.
  - If it coincides with a FINISH update, the clear wins and improved_o stays 0.
- Arithmetic:
  - The accumulator is DW bits and cannot overflow.
  - mode_i changes during a run have no effect.

## Timing
- With start_i sampled at edge 0, pat_o=0 is valid after edge 0.
- Pattern k is sampled at edge (k+1)·SETTLE.
- done_o is high in the cycle after edge 2^N_IN·SETTLE+1, and busy_o is low in that same cycle.
- Run latency, from the start edge to done_o asserted, is 2^N_IN·SETTLE+1 cycles.
- The next start_i is accepted on the edge on which done_o is sampled high.
- dut_i and exp_i are sampled only on sample edges; other values are don't-care.

## Test plan
- N_IN=4, N_OUT=1, SETTLE=1, mode 0, candidate = 4-input XOR → dist 0, matches 16, best 0, improved pulse; done asserted 17 cycles after the start edge.
- Same configuration, candidate = constant 0 → dist 8, matches 0 (half rule), total 16.
- Same configuration, candidate = 4-input AND, run after the XOR run → dist 9, matches 7, best stays 0, no improved pulse.
- SETTLE=3, mode 3, exp_i = ~pat_o[0], candidate = pat_o[0] → dist 16, matches 0; pat_o changes every 3 cycles; done asserted 49 cycles after the start edge.
- abort_i during pattern 5 → aborted_o pulse, busy low next cycle, dist_o unchanged from the prior run; a start on the following cycle is accepted.
- Reset asserted mid-run, and separately clear_best_i coincident with FINISH → all outputs at reset values; best_dist_o all-ones with improved_o 0.
